// File: rtl/microcode_store.sv
// Microcode control store: DEPTH x WORD_W array with a registered read port,
// a direct single-word write port and a beat-assembling bulk loader FSM.
module microcode_store #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 9,
  parameter int LOAD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_reject,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [LOAD_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BEATS  = WORD_W / LOAD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WORD_W-1:0] asm_word;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              direct_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // A direct write may not race the loader, including on the start cycle.
  assign direct_ok = wr_en && (state == IDLE) && !ld_start;

  assign ld_ready = (state == LOAD);
  assign ld_busy  = (state != IDLE);
  assign ld_done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ld_start) state_nxt = (ld_count == '0) ? DONE : LOAD;
      LOAD:    if (ld_valid && beat_cnt == LAST_BEAT) state_nxt = COMMIT;
      COMMIT:  state_nxt = (remaining == (ADDR_W+1)'(1)) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      asm_word  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_start) begin
            ptr       <= ld_base;
            remaining <= ld_count;
            beat_cnt  <= '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (int'(beat_cnt) == k) asm_word[k*LOAD_W +: LOAD_W] <= ld_data;
            end
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        COMMIT: begin
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          beat_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Loader commits and direct writes are mutually exclusive by state.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state == COMMIT) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = asm_word;
      end else if (direct_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array itself is never reset; only control and output registers are.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_reject <= 1'b0;
    else       wr_reject <= wr_en && !direct_ok;
  end

endmodule

// File: tb/tb_microcode_store.sv
// Scoreboard bench for microcode_store: reads push expected words into a queue,
// a negedge monitor pops and compares whenever rd_valid is presented.
module tb_microcode_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_reject;
  logic        ld_start;
  logic [8:0]  ld_base;
  logic [9:0]  ld_count;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;

  microcode_store dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_reject (wr_reject),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_count  (ld_count),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    bit          care;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] beat_src [0:31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got rd_valid with data %h, expected no read", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.care) check(e.name, rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [8:0] addr, input logic [63:0] exp, input bit care, input string name);
    exp_t e;
    e.data = exp;
    e.care = care;
    e.name = name;
    exp_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en = 1'b0;
  endtask

  task automatic dwrite(input logic [8:0] addr, input logic [63:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en = 1'b0;
    check("wr_accept", {63'd0, wr_reject}, 64'd0);
  endtask

  task automatic fill_beats(input logic [7:0] start);
    for (int i = 0; i < 32; i++) beat_src[i] = start + 8'(i);
  endtask

  // Drives one bulk load; returns the cycle offset of ld_done, the number of
  // COMMIT cycles seen and the number of beats consumed.
  task automatic run_load(input logic [8:0] base, input logic [9:0] count, input int nbeats,
                          input bit throttle, input bit inject, input int stop_at,
                          output int done_at, output int commits, output int taken);
    int  cyc;
    bit  acc;
    done_at  = -1;
    commits  = 0;
    taken    = 0;
    ld_start = 1'b1;
    ld_base  = base;
    ld_count = count;
    step();
    ld_start = 1'b0;
    cyc = 1;
    while (cyc < 200 && done_at < 0 && taken < stop_at) begin
      if (ld_done) done_at = cyc;
      if (ld_busy && !ld_ready && !ld_done) commits++;
      if (inject && cyc == 2) begin
        check("wr_reject_in_load", {63'd0, wr_reject}, 64'd1);
        wr_en    = 1'b0;
        ld_start = 1'b0;
      end
      if (inject && cyc == 1) begin
        wr_en    = 1'b1;
        wr_addr  = 9'h040;
        wr_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        ld_start = 1'b1;
        ld_base  = 9'h050;
        ld_count = 10'd3;
      end
      ld_valid = (taken < nbeats) && (!throttle || (cyc % 2 == 1));
      ld_data  = beat_src[taken % 32];
      acc      = ld_ready && ld_valid;
      step();
      cyc++;
      if (acc) taken++;
    end
    ld_valid = 1'b0;
    wr_en    = 1'b0;
    ld_start = 1'b0;
  endtask

  int d, c, n;

  initial begin
    reset    = 1'b1;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_count = '0;
    ld_valid = 1'b0;
    ld_data  = '0;

    step();
    step();
    check("rst_rd_data",   rd_data, 64'd0);
    check("rst_rd_valid",  {63'd0, rd_valid}, 64'd0);
    check("rst_wr_reject", {63'd0, wr_reject}, 64'd0);
    check("rst_ld_ready",  {63'd0, ld_ready}, 64'd0);
    check("rst_ld_busy",   {63'd0, ld_busy}, 64'd0);
    check("rst_ld_done",   {63'd0, ld_done}, 64'd0);
    reset = 1'b0;

    rd(9'h000, 64'd0, 1'b0, "rd_after_reset");
    check("rd_after_reset_valid", {63'd0, rd_valid}, 64'd1);

    // Direct write, then same-cycle read/write returns the prior word.
    dwrite(9'h05A, 64'h1111_1111_1111_1111);
    begin
      exp_t e;
      e.data = 64'h1111_1111_1111_1111;
      e.care = 1'b1;
      e.name = "rd_before_write";
      exp_q.push_back(e);
    end
    wr_en   = 1'b1;
    wr_addr = 9'h05A;
    wr_data = 64'h0123_4567_89AB_CDEF;
    rd_en   = 1'b1;
    rd_addr = 9'h05A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wr_accept_rbw", {63'd0, wr_reject}, 64'd0);
    rd(9'h05A, 64'h0123_4567_89AB_CDEF, 1'b1, "rd_05a");
    step();
    check("rd_idle_valid", {63'd0, rd_valid}, 64'd0);
    check("rd_hold_data",  rd_data, 64'h0123_4567_89AB_CDEF);

    dwrite(9'h020, 64'h2020_2020_2020_2020);
    dwrite(9'h021, 64'h2121_2121_2121_2121);
    dwrite(9'h040, 64'h4040_4040_4040_4040);
    dwrite(9'h050, 64'h5050_5050_5050_5050);
    dwrite(9'h070, 64'h7070_7070_7070_7070);

    // Two-word load with ld_valid held high.
    fill_beats(8'h00);
    run_load(9'h010, 10'd2, 16, 1'b0, 1'b0, 1000, d, c, n);
    check("load2_done_cycle", 64'(d), 64'd19);
    check("load2_commits",    64'(c), 64'd2);
    check("load2_beats",      64'(n), 64'd16);
    check("load2_idle_after", {63'd0, ld_busy}, 64'd0);
    rd(9'h010, 64'h0706_0504_0302_0100, 1'b1, "load2_w0");
    rd(9'h011, 64'h0F0E_0D0C_0B0A_0908, 1'b1, "load2_w1");

    // Wrap-around, continuous then throttled.
    fill_beats(8'h10);
    run_load(9'h1FF, 10'd2, 16, 1'b0, 1'b0, 1000, d, c, n);
    check("wrap_done_cycle", 64'(d), 64'd19);
    rd(9'h1FF, 64'h1716_1514_1312_1110, 1'b1, "wrap_w0");
    rd(9'h000, 64'h1F1E_1D1C_1B1A_1918, 1'b1, "wrap_w1");
    dwrite(9'h1FF, 64'hAAAA_AAAA_AAAA_AAAA);
    dwrite(9'h000, 64'h5555_5555_5555_5555);
    run_load(9'h1FF, 10'd2, 16, 1'b1, 1'b0, 1000, d, c, n);
    check("thr_done_cycle", 64'(d), 64'd33);
    check("thr_commits",    64'(c), 64'd2);
    rd(9'h1FF, 64'h1716_1514_1312_1110, 1'b1, "thr_w0");
    rd(9'h000, 64'h1F1E_1D1C_1B1A_1918, 1'b1, "thr_w1");

    // Direct write and second start during a one-word load are dropped.
    fill_beats(8'h80);
    run_load(9'h030, 10'd1, 8, 1'b0, 1'b1, 1000, d, c, n);
    check("rej_done_cycle", 64'(d), 64'd10);
    check("rej_commits",    64'(c), 64'd1);
    rd(9'h030, 64'h8786_8584_8382_8180, 1'b1, "rej_w0");
    rd(9'h040, 64'h4040_4040_4040_4040, 1'b1, "rej_wr_target");
    rd(9'h050, 64'h5050_5050_5050_5050, 1'b1, "rej_start_base");

    // Zero-count load.
    run_load(9'h070, 10'd0, 0, 1'b0, 1'b0, 1000, d, c, n);
    check("zero_done_cycle", 64'(d), 64'd1);
    check("zero_commits",    64'(c), 64'd0);
    check("zero_idle_t2",    {63'd0, ld_busy}, 64'd0);
    rd(9'h070, 64'h7070_7070_7070_7070, 1'b1, "zero_unchanged");

    // Reset after word 0 commits and three beats of word 1.
    fill_beats(8'h40);
    run_load(9'h020, 10'd2, 16, 1'b0, 1'b0, 11, d, c, n);
    check("mid_commits", 64'(c), 64'd1);
    check("mid_beats",   64'(n), 64'd11);
    check("mid_busy_before_reset", {63'd0, ld_busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_ld_ready", {63'd0, ld_ready}, 64'd0);
    check("mid_ld_busy",  {63'd0, ld_busy}, 64'd0);
    rd(9'h020, 64'h4746_4544_4342_4140, 1'b1, "mid_w0_kept");
    rd(9'h021, 64'h2121_2121_2121_2121, 1'b1, "mid_w1_old");

    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microcode_store.md
# microcode_store

Parametrised synchronous microcode control store with a built-in bulk loader. A host streams narrow beats (default 8 bits) into the loader; an FSM assembles them into full microwords and writes them to consecutive control-store addresses. The sequencer reads the store through a registered read port with one-cycle latency. The block sits between the front-panel/host load path and the microsequencer. It replaces the unclocked, `_w`-strobed control-store RAM.

## Interface

Parameters:
- `WORD_W`, default 64: microword width in bits.
- `ADDR_W`, default 9: address width. DEPTH = 2^ADDR_W, which is 512 by default.
- `LOAD_W`, default 8: loader beat width. `WORD_W` must be an integer multiple of `LOAD_W`. BEATS = `WORD_W`/`LOAD_W`.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_en` in 1: read request.
- `rd_addr` in `ADDR_W`: read address.
- `rd_data` out `WORD_W`: registered read data.
- `rd_valid` out 1: high for one cycle when `rd_data` holds the result of a request.
- `wr_en` in 1: direct single-word write.
- `wr_addr` in `ADDR_W`: direct write address.
- `wr_data` in `WORD_W`: direct write data.
- `wr_reject` out 1: one-cycle pulse when a direct write is dropped.
- `ld_start` in 1: begin a bulk load.
- `ld_base` in `ADDR_W`: first word address, sampled on `ld_start`.
- `ld_count` in `ADDR_W`+1: number of words, 0 to DEPTH, sampled on `ld_start`.
- `ld_valid` in 1: beat valid.
- `ld_data` in `LOAD_W`: beat data.
- `ld_ready` out 1: loader accepts a beat this cycle.
- `ld_busy` out 1: loader is not IDLE.
- `ld_done` out 1: one-cycle pulse when a load completes.

## Operation

**Memory**
- DEPTH x `WORD_W` array.
- Contents are not cleared by `reset`.

**Read port**
- `rd_en` is sampled in cycle t; `rd_data` and `rd_valid`=1 appear in cycle t+1.
- When `rd_en`=0, `rd_valid`=0 and `rd_data` holds its last value.
- Reads are serviced in every state, including during a load.

**Direct write**
- `wr_en` is accepted only when the FSM is IDLE and `ld_start`=0. The array is written at the end of that cycle.
- Otherwise the write is dropped and `wr_reject`=1 in the next cycle.

**Loader FSM**: IDLE, LOAD, COMMIT, DONE.
- IDLE:
  - `ld_start`=1 with `ld_count`=0 → DONE. No writes occur.
  - `ld_start`=1 with `ld_count`>0 → LOAD. Latch the address pointer = `ld_base`, the remaining count = `ld_count`, and clear the beat counter.
- LOAD:
  - `ld_ready`=1.
  - Each cycle with `ld_valid`=1 stores one beat. Beat k (0-based) goes to bits [k*`LOAD_W` +: `LOAD_W`], so the first beat is least significant.
  - Acceptance of beat BEATS-1 → COMMIT.
- COMMIT:
  - `ld_ready`=0.
  - The assembled word is written to the pointer address.
  - The pointer increments modulo DEPTH, so address DEPTH-1 wraps to 0.
  - The remaining count decrements. If it becomes 0 → DONE, else → LOAD with the beat counter cleared.
- DONE: `ld_done`=1 for this one cycle, then → IDLE.
- `ld_start` outside IDLE is ignored.
- `ld_busy`=1 in LOAD, COMMIT and DONE.

**Collisions**
- A read and a write to the same address in the same cycle return the old word (read-before-write).
- `reset` asserted mid-load:
  - FSM returns to IDLE and the assembly register is cleared.
  - Words already committed stay in the array.
  - The partially assembled word is discarded.

## Timing

- Reset values: `rd_data`=0, `rd_valid`=0, `wr_reject`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0. FSM is IDLE.
- Read latency is one cycle. A write committed at the end of cycle t is visible to a read issued in cycle t+1.
- `ld_start` in cycle t → `ld_ready`=1 and `ld_busy`=1 from cycle t+1.
- Per-word cost is BEATS accepted beats + 1 COMMIT cycle. With `ld_valid` held high, a load of N words takes N*(BEATS+1) cycles after start, then the DONE cycle. For N=2 at defaults: start at t, DONE at t+19.
- Zero-count load: `ld_start` at t → `ld_done` at t+1, IDLE at t+2.
- Beats presented while `ld_ready`=0 are not consumed. The host must hold them.

## Test plan

- **Reset values:** assert `reset` for 2 cycles → all outputs 0 and FSM in IDLE. After release, `rd_en` at 0x000 returns whatever is stored there, with `rd_valid`=1 one cycle later.
- **Direct write then read:** `wr_en` at 0x05A with data 0x0123456789ABCDEF, then `rd_en` at 0x05A the next cycle → `rd_data`=0x0123456789ABCDEF one cycle later. A read to 0x05A in the same cycle as the write returns the prior value.
- **Two-word bulk load:** `ld_base`=0x010, `ld_count`=2, beats 0x00..0x0F streamed with `ld_valid` held high:
  - `ld_ready` drops in the two COMMIT cycles.
  - 0x010 = 0x0706050403020100 and 0x011 = 0x0F0E0D0C0B0A0908.
  - `ld_done` pulses at t+19.
- **Wrap-around:** `ld_base`=0x1FF, `ld_count`=2 → the second word lands at 0x000. Also check a throttled stream, with `ld_valid` toggling every other cycle, assembles identical words.
- **Rejects and ignored starts:** during a load, assert `wr_en` → `wr_reject`=1 next cycle and the target address is unchanged. A second `ld_start` has no effect on `ld_base` or count. A zero-count start gives `ld_done` at t+1 with no array change.
- **Reset mid-load:** `reset` after word 0 commits and 3 beats of word 1 → returns to IDLE. Word 0 is retained; word 1's address keeps its old contents. `ld_ready`=0.
